input_vc_buffer: RTL and testbench

INPUT_VC_BUFFER -- requirements
Module: input_vc_buffer

---
 rtl/input_vc_buffer.sv | 144 ++++++++++++++
 tb/tb_input_vc_buffer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/input_vc_buffer.sv
// rtl/input_vc_buffer.sv - per-VC input flit FIFO with IDLE/VA/ACTIVE packet control

package noc_params;
    localparam int VC_NUM  = 4;
    localparam int VC_SIZE = $clog2(VC_NUM);
    typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;
endpackage

module input_vc_buffer
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = 8,
    parameter int FLIT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLIT_W-1:0]  data_i,
    input  logic [1:0]         type_i,
    input  logic               valid_flit_i,
    input  port_t              out_port_i,
    input  logic               read_i,
    input  logic [VC_SIZE-1:0] vc_new_i,
    input  logic               vc_valid_i,
    output logic [FLIT_W-1:0]  data_o,
    output logic [1:0]         type_o,
    output port_t              out_port_o,
    output logic [VC_SIZE-1:0] vc_o,
    output logic               vc_request_o,
    output logic               switch_request_o,
    output logic               is_full_o,
    output logic               is_empty_o,
    output logic               idle_o,
    output logic               error_o
);

    localparam int IW = $clog2(BUFFER_SIZE);
    localparam int PW = IW + 1;

    localparam logic [1:0] HEAD     = 2'd0;
    localparam logic [1:0] BODY     = 2'd1;
    localparam logic [1:0] TAIL     = 2'd2;
    localparam logic [1:0] HEADTAIL = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_VA, S_ACTIVE} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       rd_q, rd_d, wr_q, wr_d;
    port_t               out_port_q, out_port_d;
    logic [VC_SIZE-1:0]  vc_q, vc_d;
    logic                error_q, error_d;
    logic [FLIT_W-1:0]   data_mem_q [BUFFER_SIZE];
    logic [1:0]          type_mem_q [BUFFER_SIZE];

    logic empty, full, read_acc, write_acc, is_head, legal, front_is_tail;

    // FIFO status and acceptance of the flit / grant offered this cycle
    always_comb begin
        empty         = (rd_q == wr_q);
        full          = (rd_q[IW-1:0] == wr_q[IW-1:0]) && (rd_q[IW] != wr_q[IW]);
        front_is_tail = (type_mem_q[rd_q[IW-1:0]] == TAIL) ||
                        (type_mem_q[rd_q[IW-1:0]] == HEADTAIL);
        read_acc      = read_i && (state_q == S_ACTIVE) && !empty;
        is_head       = (type_i == HEAD) || (type_i == HEADTAIL);
        // a head may only open a packet into an empty idle VC; body/tail only inside a packet
        legal         = valid_flit_i && ((state_q == S_IDLE) ? (is_head && empty) : !is_head);
        // a full FIFO still takes a write when the same cycle frees a slot
        write_acc     = legal && (!full || read_acc);
        error_d       = (valid_flit_i && !legal) || (legal && !write_acc) ||
                        (read_i && !read_acc);
        rd_d          = rd_q + PW'(read_acc);
        wr_d          = wr_q + PW'(write_acc);
    end

    // packet-level control: route latch, VC allocation, tail release
    always_comb begin
        state_d          = state_q;
        out_port_d       = out_port_q;
        vc_d             = vc_q;
        vc_request_o     = 1'b0;
        switch_request_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (write_acc) begin
                    out_port_d = out_port_i;
                    state_d    = S_VA;
                end
            end
            S_VA: begin
                vc_request_o = 1'b1;
                if (vc_valid_i) begin
                    vc_d    = vc_new_i;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                switch_request_o = !empty;
                if (read_acc && front_is_tail) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // control and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_q       <= '0;
            wr_q       <= '0;
            out_port_q <= LOCAL;
            vc_q       <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            out_port_q <= out_port_d;
            vc_q       <= vc_d;
            error_q    <= error_d;
        end
    end

    // flit storage, cleared on reset so the front outputs never show X
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                data_mem_q[i] <= '0;
                type_mem_q[i] <= '0;
            end
        end else if (write_acc) begin
            data_mem_q[wr_q[IW-1:0]] <= data_i;
            type_mem_q[wr_q[IW-1:0]] <= type_i;
        end
    end

    assign data_o     = data_mem_q[rd_q[IW-1:0]];
    assign type_o     = type_mem_q[rd_q[IW-1:0]];
    assign out_port_o = out_port_q;
    assign vc_o       = vc_q;
    assign is_full_o  = full;
    assign is_empty_o = empty;
    assign idle_o     = (state_q == S_IDLE) && empty;
    assign error_o    = error_q;

endmodule

// File: tb/tb_input_vc_buffer.sv
// tb/tb_input_vc_buffer.sv - self-checking bench for input_vc_buffer against a queue model

module tb_input_vc_buffer;
    import noc_params::*;

    localparam int BS = 8;
    localparam int FW = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [FW-1:0]      data_i = '0;
    logic [1:0]         type_i = '0;
    logic               valid_flit_i = 1'b0;
    port_t              out_port_i = LOCAL;
    logic               read_i = 1'b0;
    logic [VC_SIZE-1:0] vc_new_i = '0;
    logic               vc_valid_i = 1'b0;
    logic [FW-1:0]      data_o;
    logic [1:0]         type_o;
    port_t              out_port_o;
    logic [VC_SIZE-1:0] vc_o;
    logic               vc_request_o, switch_request_o, is_full_o, is_empty_o, idle_o, error_o;

    int checks = 0;
    int failures = 0;

    // model: queue of {type,data}; phase 0=idle, 1=waiting for VC, 2=active
    logic [FW+1:0]      mq[$];
    int                 mphase;
    port_t              mport;
    logic [VC_SIZE-1:0] mvc;
    logic               merr;

    input_vc_buffer #(.BUFFER_SIZE(BS), .FLIT_W(FW)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .type_i(type_i),
        .valid_flit_i(valid_flit_i), .out_port_i(out_port_i), .read_i(read_i),
        .vc_new_i(vc_new_i), .vc_valid_i(vc_valid_i), .data_o(data_o), .type_o(type_o),
        .out_port_o(out_port_o), .vc_o(vc_o), .vc_request_o(vc_request_o),
        .switch_request_o(switch_request_o), .is_full_o(is_full_o), .is_empty_o(is_empty_o),
        .idle_o(idle_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mphase = 0;
        mport  = LOCAL;
        mvc    = '0;
        merr   = 1'b0;
    endtask

    task automatic compare_all();
        int n;
        n = mq.size();
        chk("is_empty", is_empty_o, n == 0);
        chk("is_full", is_full_o, n == BS);
        chk("idle", idle_o, (mphase == 0) && (n == 0));
        chk("vc_request", vc_request_o, mphase == 1);
        chk("switch_request", switch_request_o, (mphase == 2) && (n != 0));
        chk("vc_o", vc_o, mvc);
        chk("out_port", out_port_o, mport);
        chk("error", error_o, merr);
        if (n != 0) begin
            chk("front_type", type_o, mq[0][FW+1:FW]);
            chk("front_data", data_o, mq[0][FW-1:0]);
        end
    endtask

    // apply one cycle of stimulus, advance the model across the edge, then compare
    task automatic step(input logic v, input logic [1:0] t, input logic [FW-1:0] d,
                        input port_t p, input logic rd, input logic vv,
                        input logic [VC_SIZE-1:0] vn);
        bit empty, full, racc, head, legal, wacc, tail_front;
        valid_flit_i = v; type_i = t; data_i = d; out_port_i = p;
        read_i = rd; vc_valid_i = vv; vc_new_i = vn;
        @(posedge clk);
        empty = (mq.size() == 0);
        full  = (mq.size() == BS);
        racc  = rd && (mphase == 2) && !empty;
        tail_front = !empty && (mq[0][FW+1:FW] >= 2);
        head  = (t == 2'd0) || (t == 2'd3);
        legal = v && ((mphase == 0) ? (head && empty) : !head);
        wacc  = legal && (!full || racc);
        merr  = (v && !legal) || (legal && !wacc) || (rd && !racc);
        if (mphase == 0 && wacc) begin
            mport  = p;
            mphase = 1;
        end else if (mphase == 1 && vv) begin
            mvc    = vn;
            mphase = 2;
        end else if (mphase == 2 && racc && tail_front) begin
            mphase = 0;
        end
        if (racc) void'(mq.pop_front());
        if (wacc) mq.push_back({t, d});
        #1;
        compare_all();
    endtask

    task automatic idle_cycle();
        step(1'b0, 2'd1, '0, LOCAL, 1'b0, 1'b0, '0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
        idle_cycle();

        // three-flit packet: head/body/tail, grant two cycles after head, then three reads
        step(1'b1, 2'd0, 32'hA0, EAST,  1'b0, 1'b0, '0);
        step(1'b1, 2'd1, 32'hA1, LOCAL, 1'b0, 1'b0, '0);
        step(1'b1, 2'd2, 32'hA2, LOCAL, 1'b0, 1'b1, 2'd1);
        chk("d1_vc", vc_o, 2'd1);
        chk("d1_port", out_port_o, EAST);
        chk("d1_swreq", switch_request_o, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd1, '0, LOCAL, 1'b1, 1'b0, '0);
        chk("d1_idle", idle_o, 1'b1);

        // fill to capacity, overflow, then simultaneous read/write while full
        step(1'b1, 2'd0, 32'hB0, NORTH, 1'b0, 1'b0, '0);
        for (int i = 1; i < BS; i++) step(1'b1, 2'd1, 32'hB0 + i, LOCAL, 1'b0, 1'b0, '0);
        step(1'b1, 2'd1, 32'hBF, LOCAL, 1'b0, 1'b1, 2'd2);
        chk("d2_full", is_full_o, 1'b1);
        idle_cycle();
        chk("d2_err_once", error_o, 1'b0);
        step(1'b1, 2'd2, 32'hBE, LOCAL, 1'b1, 1'b0, '0);
        chk("d2_still_full", is_full_o, 1'b1);
        for (int i = 0; i < BS; i++) step(1'b0, 2'd1, '0, LOCAL, 1'b1, 1'b0, '0);

        // single-flit packet
        step(1'b1, 2'd3, 32'hC3, LOCAL, 1'b0, 1'b0, '0);
        step(1'b0, 2'd1, '0, LOCAL, 1'b0, 1'b1, 2'd0);
        chk("d3_type", type_o, 2'd3);
        step(1'b0, 2'd1, '0, LOCAL, 1'b1, 1'b0, '0);
        chk("d3_idle", idle_o, 1'b1);

        // protocol violations: body in idle, head during VA, read while empty in active
        step(1'b1, 2'd1, 32'hD0, LOCAL, 1'b0, 1'b0, '0);
        step(1'b1, 2'd0, 32'hD1, WEST,  1'b0, 1'b0, '0);
        step(1'b1, 2'd0, 32'hD2, SOUTH, 1'b0, 1'b0, '0);
        step(1'b0, 2'd1, '0, LOCAL, 1'b1, 1'b1, 2'd3);
        step(1'b0, 2'd1, '0, LOCAL, 1'b1, 1'b0, '0);
        step(1'b0, 2'd1, '0, LOCAL, 1'b1, 1'b0, '0);
        chk("d4_err_empty_read", error_o, 1'b1);
        step(1'b1, 2'd2, 32'hD3, LOCAL, 1'b0, 1'b0, '0);
        step(1'b0, 2'd1, '0, LOCAL, 1'b1, 1'b0, '0);

        // mid-packet reset with three flits stored
        step(1'b1, 2'd0, 32'hE0, NORTH, 1'b0, 1'b0, '0);
        step(1'b1, 2'd1, 32'hE1, LOCAL, 1'b0, 1'b1, 2'd2);
        step(1'b1, 2'd1, 32'hE2, LOCAL, 1'b0, 1'b0, '0);
        valid_flit_i = 1'b0; read_i = 1'b0; vc_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 2'd1, 32'hF0, LOCAL, 1'b0, 1'b0, '0);
        step(1'b1, 2'd0, 32'hF1, SOUTH, 1'b0, 1'b0, '0);
        chk("d5_port", out_port_o, SOUTH);

        // randomized traffic biased towards well-formed packets
        for (int i = 0; i < 1500; i++) begin
            logic [1:0] t;
            int r;
            r = $urandom_range(0, 99);
            if (mphase == 0) t = (r < 80) ? ((r < 40) ? 2'd0 : 2'd3) : 2'd1;
            else             t = (r < 8) ? 2'd0 : ((r < 30) ? 2'd2 : 2'd1);
            step($urandom_range(0, 99) < 70, t, $urandom, port_t'($urandom_range(0, 4)),
                 $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40,
                 VC_SIZE'($urandom_range(0, VC_NUM - 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
